spi_peripheral: RTL and testbench

SPI write-only register-file front end for the onboarding design. It sits directly upstream of `pwm_peripheral` in `tt_um_uwasic_onboarding_ycchoo` and is driven from `ui_in[0]` (SCLK), `ui_in[1]` (COPI) and `ui_in[2]` (nCS). It captures 16-bit SPI frames in SPI mode 0, MSB first, and writes the addressed configuration byte. It drives the five register outputs that `pwm_peripheral` consumes.

---
 rtl/spi_peripheral.sv | 93 +++++++++
 tb/tb_spi_peripheral.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only front end: 16-bit frames {rw, addr[6:0], data[7:0]}
// MSB first, committed on nCS rise into five 8-bit configuration registers.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   sclk, copi, ncs   raw SPI pins, asynchronous to clk
//   en_reg_out_7_0    addr 0x00
//   en_reg_out_15_8   addr 0x01
//   en_reg_pwm_7_0    addr 0x02
//   en_reg_pwm_15_8   addr 0x03
//   pwm_duty_cycle    addr 0x04
module spi_peripheral (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    // [0],[1] synchroniser; [2] previous synchronised value
    logic [2:0] sclk_q;
    logic [2:0] ncs_q;
    logic [1:0] copi_q;

    logic [4:0]  bit_cnt;
    logic [15:0] shift;

    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;
    logic commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 3'b000;
            ncs_q  <= 3'b000;
            copi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ncs_q  <= {ncs_q[1:0], ncs};
            copi_q <= {copi_q[0], copi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
    assign ncs_rise  = ncs_q[1] & ~ncs_q[2];

    assign commit = ncs_rise && (bit_cnt == 5'd16) && shift[15]
                    && (shift[14:8] <= 7'd4);

    // nCS edges take priority over a coincident SCLK edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 5'd0;
            shift   <= 16'h0000;
        end else if (ncs_fall) begin
            bit_cnt <= 5'd0;
            shift   <= 16'h0000;
        end else if (!ncs_rise && !ncs_q[1] && sclk_rise) begin
            shift <= {shift[14:0], copi_q[1]};
            // Saturate at 17 so over-long frames never look valid again.
            if (bit_cnt != 5'd17) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else if (commit) begin
            case (shift[10:8])
                3'd0:    en_reg_out_7_0  <= shift[7:0];
                3'd1:    en_reg_out_15_8 <= shift[7:0];
                3'd2:    en_reg_pwm_7_0  <= shift[7:0];
                3'd3:    en_reg_pwm_15_8 <= shift[7:0];
                3'd4:    pwm_duty_cycle  <= shift[7:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Testbench for spi_peripheral: directed and random SPI frames checked
// against a register-array model, including commit latency and resets.
module tb_spi_peripheral;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mreg [5];

    spi_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] obs_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] exp_regs();
        return {mreg[4], mreg[3], mreg[2], mreg[1], mreg[0]};
    endfunction

    task automatic check(input string tag);
        logic [39:0] o;
        logic [39:0] e;
        o = obs_regs();
        e = exp_regs();
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 5; i++) mreg[i] = 8'h00;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b);
        copi = b;
        wait_neg(4);
        sclk = 1'b1;
        wait_neg(4);
        sclk = 1'b0;
    endtask

    // Sends n bits: the first min(n,16) MSBs of f, padded with 1s past 16.
    // Checks the register update lands exactly on the 3rd edge after nCS rise.
    task automatic send(input logic [15:0] f, input int n, input string tag);
        @(negedge clk);
        ncs = 1'b0;
        wait_neg(4);
        for (int i = 0; i < n; i++) begin
            bit_out(i < 16 ? f[15-i] : 1'b1);
        end
        wait_neg(4);
        ncs = 1'b1;
        @(posedge clk); #1;
        check({tag, "_k"});
        @(posedge clk); #1;
        check({tag, "_k1"});
        @(posedge clk); #1;
        if (n == 16 && f[15] && f[14:8] <= 7'd4) begin
            mreg[f[10:8]] = f[7:0];
        end
        check({tag, "_k2"});
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        clear_model();
        check(tag);
        wait_neg(3);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] f;
        int          n;
        int          r;

        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        clear_model();
        wait_neg(4);
        check("reset_state");
        rst_n = 1'b1;
        wait_neg(6);
        check("after_release");

        send(16'h80F0, 16, "wr_addr0");
        send(16'h84CC, 16, "wr_addr4");

        send(16'h0155, 16, "read_frame");
        send(16'h8A33, 16, "bad_addr");

        send(16'h82AA, 15, "short_frame");
        send(16'h82AA, 17, "long_frame");
        send(16'h82AA, 16, "good_frame");

        // Reset after 10 bits of 0x8311, then release nCS.
        @(negedge clk);
        ncs = 1'b0;
        wait_neg(4);
        f = 16'h8311;
        for (int i = 0; i < 10; i++) bit_out(f[15-i]);
        wait_neg(2);
        async_reset("midframe_reset");
        wait_neg(4);
        ncs = 1'b1;
        wait_neg(6);
        check("midframe_dropped");
        send(16'h8311, 16, "refill_addr3");

        send(16'h8011, 16, "b2b_0");
        send(16'h8122, 16, "b2b_1");
        send(16'h8233, 16, "b2b_2");
        send(16'h8344, 16, "b2b_3");
        send(16'h8455, 16, "b2b_4");

        async_reset("async_reset");
        wait_neg(4);

        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 9);
            n = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            f[15]   = ($urandom_range(0, 3) != 0);
            f[14:8] = 7'($urandom_range(0, 7));
            f[7:0]  = 8'($urandom_range(0, 255));
            send(f, n, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
